// File: rtl/pe_ws.sv
// pe_ws: weight-stationary MAC cell with a double-buffered weight and daisy-chained weight loading.
// Define PE_SAT_EN to saturate on overflow; otherwise sums wrap and sat is tied low.
module pe_ws #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_load,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_swap,
    output logic [DATA_W-1:0] w_out,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ACC_W-1:0]  psum_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ACC_W-1:0]  psum_out,
    output logic              sat
);

    localparam int PROD_W    = 2 * DATA_W;
    localparam bit IS_SIGNED = (SIGNED != 0);

    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] active_q;
    logic [PROD_W-1:0] data_x;
    logic [PROD_W-1:0] weight_x;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_a;
    logic [ACC_W-1:0]  result;

    // Swap reads shadow_q before this edge's load, so load+swap together moves the old shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (w_load) shadow_q <= w_in;
            if (w_swap) active_q <= shadow_q;
        end
    end

    assign w_out = shadow_q;

    always_comb begin
        data_x   = {{DATA_W{IS_SIGNED && in_data[DATA_W-1]}}, in_data};
        weight_x = {{DATA_W{IS_SIGNED && active_q[DATA_W-1]}}, active_q};
        prod     = data_x * weight_x;
        if (IS_SIGNED) prod_a = ACC_W'($signed(prod));
        else           prod_a = ACC_W'(prod);
    end

`ifdef PE_SAT_EN
    logic [ACC_W:0]   psum_e;
    logic [ACC_W:0]   prod_e;
    logic [ACC_W:0]   sum_e;
    logic [ACC_W-1:0] clip;
    logic             ovf;

    // One guard bit is enough: both addends fit in ACC_W bits of the chosen signedness.
    always_comb begin
        psum_e = {IS_SIGNED && psum_in[ACC_W-1], psum_in};
        prod_e = {IS_SIGNED && prod_a[ACC_W-1], prod_a};
        sum_e  = psum_e + prod_e;
        ovf    = 1'b0;
        clip   = '1;
        if (IS_SIGNED) begin
            ovf  = sum_e[ACC_W] ^ sum_e[ACC_W-1];
            clip = sum_e[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            ovf  = sum_e[ACC_W];
        end
        result = ovf ? clip : sum_e[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           sat <= 1'b0;
        else if (in_valid) sat <= ovf;
    end
`else
    always_comb begin
        result = psum_in + prod_a;
    end

    assign sat = 1'b0;
`endif

    // Data registers only move on valid inputs so idle cycles do not toggle the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            psum_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
                psum_out <= result;
            end
        end
    end

endmodule
